// File: rtl/pg_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and default field width.
package pg_pkg;

  localparam int PG_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } pg_state_e;

endpackage

// File: rtl/pg_down_counter.sv
// Loadable down-counter that times every phase of the pulse train.
// Load wins over decrement; the count saturates at zero, where tc_o is high.
module pg_down_counter
  import pg_pkg::*;
#(
  parameter int WIDTH = PG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: optional start delay, then n_pulses pulses of
// high cycles separated by low cycles, or an endless train until abort.
module pulse_train_gen
  import pg_pkg::*;
#(
  parameter int WIDTH = PG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] delay,
  input  logic [WIDTH-1:0] high,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] n_pulses,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulse_count
);

  pg_state_e        state_q, state_d;
  logic [WIDTH-1:0] hm1_q, hm1_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] hm1_in;
  logic [WIDTH-1:0] pc_inc;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_tc;

  // A zero high time behaves as one cycle, so the stored reload value is max(high,1)-1.
  assign hm1_in = (high == '0) ? '0 : (high - WIDTH'(1));

  pg_down_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .tc_o      (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    hm1_d    = hm1_q;
    low_d    = low_q;
    n_d      = n_q;
    pc_d     = pc_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    pc_inc   = pc_q + WIDTH'(1);

    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            hm1_d    = hm1_in;
            low_d    = low;
            n_d      = n_pulses;
            pc_d     = '0;
            cnt_load = 1'b1;
            if (delay != '0) begin
              state_d = ST_DELAY;
              cnt_val = delay - WIDTH'(1);
            end else begin
              state_d = ST_HIGH;
              cnt_val = hm1_in;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_tc) begin
            state_d  = ST_HIGH;
            cnt_load = 1'b1;
            cnt_val  = hm1_q;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_tc) begin
            pc_d = pc_inc;
            // n_pulses of zero never matches, so continuous trains only end on abort.
            if ((n_q != '0) && (pc_inc == n_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (low_q != '0) begin
              state_d  = ST_LOW;
              cnt_load = 1'b1;
              cnt_val  = low_q - WIDTH'(1);
            end else begin
              cnt_load = 1'b1;
              cnt_val  = hm1_q;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt_tc) begin
            state_d  = ST_HIGH;
            cnt_load = 1'b1;
            cnt_val  = hm1_q;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hm1_q   <= '0;
      low_q   <= '0;
      n_q     <= '0;
      pc_q    <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hm1_q   <= hm1_d;
      low_q   <= low_d;
      n_q     <= n_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out         = out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = pc_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed table, randomized trains against a
// cycle-index arithmetic model, and hand-written reset/abort/restart sequences.
module tb_pulse_train_gen;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] delay = '0;
  logic [W-1:0] high = '0;
  logic [W-1:0] low = '0;
  logic [W-1:0] n_pulses = '0;
  logic         out;
  logic         busy;
  logic         done;
  logic [W-1:0] pulse_count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic         o;
    logic         b;
    logic         d;
    logic [W-1:0] pc;
  } obs_t;

  typedef struct {
    int d;
    int h;
    int l;
    int n;
    int exp_done;
    int exp_pc;
    bit garble;
  } vec_t;

  pulse_train_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .delay      (delay),
    .high       (high),
    .low        (low),
    .n_pulses   (n_pulses),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  // Expected outputs in cycle c (c=1 is the cycle right after the accepting edge),
  // derived from the train's time line: D delay cycles, then periods of H high + L low.
  function automatic obs_t model(input int c, input int d, input int h, input int l, input int n);
    obs_t e;
    int hh;
    int t;
    int u;
    int p;
    int r;
    int last;
    e = '0;
    hh = (h == 0) ? 1 : h;
    t = c - 1;
    if (t < d) begin
      e.b = 1'b1;
      return e;
    end
    u = t - d;
    if (n != 0) begin
      last = n * hh + (n - 1) * l;
      if (u >= last) begin
        e.d = (u == last);
        e.pc = W'(n);
        return e;
      end
    end
    p = u / (hh + l);
    r = u % (hh + l);
    e.b = 1'b1;
    e.o = (r < hh);
    e.pc = W'((r < hh) ? p : p + 1);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.o = out;
    s.b = busy;
    s.d = done;
    s.pc = pulse_count;
    return s;
  endfunction

  task automatic cmp(input string name, input int c, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got out=%b busy=%b done=%b pc=%0d, expected out=%b busy=%b done=%b pc=%0d",
               name, c, act.o, act.b, act.d, act.pc, exp.o, exp.b, exp.d, exp.pc);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; the train is accepted at the next rising edge.
  task automatic launch(input int d, input int h, input int l, input int n);
    delay = W'(d);
    high = W'(h);
    low = W'(l);
    n_pulses = W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks cycles 1..len and returns at the falling edge of cycle len. With garble set,
  // start and config are scrambled while busy; they must have no effect.
  task automatic check_train(input string tag, input int d, input int h, input int l, input int n,
                             input int len, input bit garble, output int done_at);
    done_at = -1;
    for (int c = 1; c <= len; c++) begin
      obs_t e;
      e = model(c, d, h, l, n);
      cmp(tag, c, sample(), e);
      if (done && (done_at < 0)) done_at = c;
      if (garble && e.b) begin
        start = 1'($urandom_range(0, 1));
        delay = W'($urandom_range(0, 15));
        high = W'($urandom_range(0, 15));
        low = W'($urandom_range(0, 15));
        n_pulses = W'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      if (c < len) @(negedge clk);
    end
    $display("train %s d=%0d h=%0d l=%0d n=%0d done_at=%0d pc=%0d", tag, d, h, l, n, done_at, pulse_count);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[5];
    int   done_at;
    int   len;
    int   d, h, l, n, hh;
    obs_t e;

    vt[0] = '{3, 2, 1, 3, 12, 3, 1'b0};
    vt[1] = '{0, 0, 0, 2, 3, 2, 1'b1};
    vt[2] = '{1, 1, 0, 1, 3, 1, 1'b0};
    vt[3] = '{0, 5, 2, 2, 13, 2, 1'b1};
    vt[4] = '{2, 0, 3, 3, 12, 3, 1'b1};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp("reset", 0, sample(), obs_t'(0));
    rst = 1'b1;
    @(negedge clk);
    cmp("after_reset", 0, sample(), obs_t'(0));

    for (int i = 0; i < 5; i++) begin
      launch(vt[i].d, vt[i].h, vt[i].l, vt[i].n);
      check_train("table", vt[i].d, vt[i].h, vt[i].l, vt[i].n, vt[i].exp_done + 2, vt[i].garble, done_at);
      cmp_int("table_done_cycle", done_at, vt[i].exp_done);
      cmp_int("table_pulse_count", int'(pulse_count), vt[i].exp_pc);
    end

    for (int i = 0; i < 25; i++) begin
      d = $urandom_range(0, 3);
      h = $urandom_range(0, 3);
      l = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      hh = (h == 0) ? 1 : h;
      len = d + n * hh + (n - 1) * l + 3;
      launch(d, h, l, n);
      check_train("random", d, h, l, n, len, 1'b1, done_at);
      cmp_int("random_done_cycle", done_at, len - 2);
    end

    // Continuous train wraps pulse_count past 15, then abort ends it without done.
    launch(0, 1, 1, 0);
    check_train("continuous", 0, 1, 1, 0, 40, 1'b1, done_at);
    cmp_int("continuous_no_done", done_at, -1);
    e = model(40, 0, 1, 1, 0);
    e.o = 1'b0;
    e.b = 1'b0;
    e.d = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cmp("abort", c, sample(), e);
      @(negedge clk);
    end

    // A start in the done cycle launches the next train immediately.
    launch(0, 1, 0, 1);
    check_train("chain_a", 0, 1, 0, 1, 2, 1'b0, done_at);
    cmp_int("chain_a_done_cycle", done_at, 2);
    launch(1, 2, 1, 2);
    check_train("chain_b", 1, 2, 1, 2, 9, 1'b1, done_at);
    cmp_int("chain_b_done_cycle", done_at, 7);

    // Asynchronous reset in the middle of a long HIGH phase.
    launch(0, 8, 0, 2);
    check_train("pre_reset", 0, 8, 0, 2, 3, 1'b0, done_at);
    #2 rst = 1'b0;
    #1 cmp("async_reset", 0, sample(), obs_t'(0));
    @(negedge clk);
    rst = 1'b1;
    launch(2, 1, 1, 2);
    check_train("post_reset", 2, 1, 1, 2, 8, 1'b0, done_at);
    cmp_int("post_reset_done_cycle", done_at, 6);

    // start and abort together in IDLE must not launch.
    delay = '0;
    high = W'(3);
    low = '0;
    n_pulses = W'(1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    e = '0;
    e.pc = W'(2);
    for (int c = 1; c <= 3; c++) begin
      cmp("start_abort_idle", c, sample(), e);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
